// File: rtl/dot_pkg.sv
// Constants and FSM state shared by the dot-matrix frame buffer and the column scanner.
package dot_pkg;

  localparam int DOT_COLS  = 10;
  localparam int DOT_ROWS  = 7;
  localparam int DOT_COL_W = 4;

  localparam logic [DOT_ROWS-1:0] DOT_BLANK = 7'h00;

  typedef enum logic [0:0] {
    FB_IDLE,
    FB_PENDING
  } fb_state_e;

endpackage

// File: rtl/dot_buf_bank.sv
// One COLS x ROWS pixel bank: synchronous write, combinational read, async clear.
module dot_buf_bank #(
  parameter int COLS  = 10,
  parameter int ROWS  = 7,
  parameter int COL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [COL_W-1:0] waddr_i,
  input  logic [ROWS-1:0]  wdata_i,
  input  logic [COL_W-1:0] raddr_i,
  output logic [ROWS-1:0]  rdata_o
);

  logic [COLS-1:0][ROWS-1:0] mem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (we_i && (waddr_i < COL_W'(COLS))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Columns past the panel edge read as blank.
  assign rdata_o = (raddr_i < COL_W'(COLS)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/dot_frame_buf.sv
// Double-buffered dot-matrix frame store; bank swap deferred to the scanner frame boundary.
module dot_frame_buf
  import dot_pkg::*;
#(
  parameter int COLS  = DOT_COLS,
  parameter int ROWS  = DOT_ROWS,
  parameter int COL_W = DOT_COL_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_EN,
  input  logic [COL_W-1:0] WR_COL,
  input  logic [ROWS-1:0]  WR_DATA,
  input  logic             COMMIT,
  input  logic [COL_W-1:0] SCAN_COL,
  input  logic             FRAME_END,
  output logic [ROWS-1:0]  ROW_DATA,
  output logic             PENDING,
  output logic             SWAP_ACK,
  output logic             WR_ERR
);

  fb_state_e state_q, state_d;
  logic      front_sel_q, front_sel_d;
  logic      swap;
  logic      wr_ok;
  logic [ROWS-1:0] row_data_q, row_data_d;
  logic      swap_ack_q, wr_err_q;

  logic [1:0]           bank_we;
  logic [1:0][ROWS-1:0] bank_rd;

  // Writes are frozen while a commit waits, so the committed frame stays intact.
  assign wr_ok = WR_EN && (WR_COL < COL_W'(COLS)) && (state_q == FB_IDLE);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_ok && (front_sel_q != 1'(b));
    dot_buf_bank #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W)) u_bank (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .we_i    (bank_we[b]),
      .waddr_i (WR_COL),
      .wdata_i (WR_DATA),
      .raddr_i (SCAN_COL),
      .rdata_o (bank_rd[b])
    );
  end

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      FB_IDLE: begin
        if (COMMIT) begin
          if (FRAME_END) swap    = 1'b1;
          else           state_d = FB_PENDING;
        end
      end
      FB_PENDING: begin
        if (FRAME_END) begin
          swap    = 1'b1;
          state_d = FB_IDLE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
  end

  assign front_sel_d = front_sel_q ^ swap;
  // Read uses the pre-swap front; the new front is visible one edge later.
  assign row_data_d  = bank_rd[front_sel_q];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= FB_IDLE;
      front_sel_q <= 1'b0;
      row_data_q  <= '0;
      swap_ack_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      row_data_q  <= row_data_d;
      swap_ack_q  <= swap;
      wr_err_q    <= WR_EN && !wr_ok;
    end
  end

  assign ROW_DATA = row_data_q;
  assign PENDING  = (state_q == FB_PENDING);
  assign SWAP_ACK = swap_ack_q;
  assign WR_ERR   = wr_err_q;

endmodule

// File: tb/tb_dot_frame_buf.sv
// Directed and random checks of dot_frame_buf against a frame-level reference model.
module tb_dot_frame_buf;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_COL = '0;
  logic [6:0] WR_DATA = '0;
  logic       COMMIT = 1'b0;
  logic [3:0] SCAN_COL = '0;
  logic       FRAME_END = 1'b0;
  logic [6:0] ROW_DATA;
  logic       PENDING, SWAP_ACK, WR_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model: two frames, which one is shown, and whether a commit waits.
  logic [6:0] frame [2][10];
  int         shown;
  bit         waiting;
  logic [6:0] exp_row;
  bit         exp_ack, exp_err;

  dot_frame_buf dut (
    .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_COL(WR_COL), .WR_DATA(WR_DATA),
    .COMMIT(COMMIT), .SCAN_COL(SCAN_COL), .FRAME_END(FRAME_END),
    .ROW_DATA(ROW_DATA), .PENDING(PENDING), .SWAP_ACK(SWAP_ACK), .WR_ERR(WR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 10; c++) frame[b][c] = 7'h00;
    shown = 0; waiting = 0;
    exp_row = 7'h00; exp_ack = 0; exp_err = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".row"},  {1'b0, ROW_DATA}, {1'b0, exp_row});
    chk({tag, ".pend"}, {7'b0, PENDING},  {7'b0, waiting});
    chk({tag, ".ack"},  {7'b0, SWAP_ACK}, {7'b0, exp_ack});
    chk({tag, ".err"},  {7'b0, WR_ERR},   {7'b0, exp_err});
  endtask

  // One clock with the given inputs; the model applies the frame rules at the edge.
  task automatic step(input string tag, input bit we, input int col, input logic [6:0] d,
                      input bit cm, input bit fe, input int scan);
    bit do_swap;
    WR_EN = we; WR_COL = 4'(col); WR_DATA = d; COMMIT = cm; FRAME_END = fe; SCAN_COL = 4'(scan);
    @(posedge CLK);
    exp_row = (scan < 10) ? frame[shown][scan] : 7'h00;
    exp_err = we && (col >= 10 || waiting);
    if (we && col < 10 && !waiting) frame[1 - shown][col] = d;
    do_swap = fe && (waiting || cm);
    if (cm && !fe) waiting = 1;
    if (do_swap) begin
      shown   = 1 - shown;
      waiting = 0;
    end
    exp_ack = do_swap;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int scan);
    step(tag, 0, 0, 7'h00, 0, 0, scan);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("rst_held");
    RESET = 1'b0;

    // 1: blank after reset
    for (int c = 0; c < 10; c++) idle("t1_sweep", c);
    idle("t1_last", 0);

    // 2: fill, commit, frame end 20 cycles later
    for (int c = 0; c < 10; c++) step("t2_wr", 1, c, 7'h3E, 0, 0, 0);
    step("t2_commit", 0, 0, 7'h00, 1, 0, 0);
    for (int i = 0; i < 19; i++) idle("t2_wait", 0);
    step("t2_fe", 0, 0, 7'h00, 0, 1, 0);
    for (int c = 0; c < 10; c++) idle("t2_scan", c);
    idle("t2_tail", 9);

    // 3: write + commit + frame end together
    step("t3_same", 1, 3, 7'h11, 1, 1, 3);
    idle("t3_ack", 3);
    idle("t3_read", 3);

    // 4: write during pending and out-of-range write
    step("t4_commit", 0, 0, 7'h00, 1, 0, 2);
    step("t4_wrpend", 1, 2, 7'h7F, 0, 0, 2);
    step("t4_fe", 0, 0, 7'h00, 0, 1, 2);
    step("t4_wr12", 1, 12, 7'h55, 0, 0, 2);
    step("t4_cm", 0, 0, 7'h00, 1, 1, 2);
    idle("t4_back2", 2);
    idle("t4_read2", 2);

    // 5: steady column across a swap
    step("t5_wr66", 1, 4, 7'h66, 1, 1, 4);
    idle("t5_a", 4);
    step("t5_wr7e", 1, 4, 7'h7E, 0, 0, 4);
    step("t5_commit", 0, 0, 7'h00, 1, 0, 4);
    step("t5_cm_again", 0, 0, 7'h00, 1, 0, 4);
    step("t5_fe", 0, 0, 7'h00, 0, 1, 4);
    idle("t5_new", 4);
    idle("t5_col11", 11);
    idle("t5_col11b", 11);

    // 6: reset while pending
    step("t6_commit", 0, 0, 7'h00, 1, 0, 4);
    #3;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge CLK); #1;
    RESET = 1'b0;
    step("t6_fe", 0, 0, 7'h00, 0, 1, 4);
    idle("t6_after", 4);
    idle("t6_after2", 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           ($urandom_range(1, 0) == 1),
           int'($urandom_range(12, 0)),
           7'($urandom),
           ($urandom_range(7, 0) == 0),
           ($urandom_range(9, 0) == 0),
           int'($urandom_range(11, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
